// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bit-slip word alignment on control tokens, then
// token / 8b data decode with a two-stage pipeline from raw_word to outputs.
module tmds_channel_decoder #(
   parameter int TOKEN_RUN     = 8,
   parameter int SEARCH_WINDOW = 2048,
   parameter int LOSS_TIMEOUT  = 2048
) (
   input  logic       pixclk,
   input  logic       reset,
   input  logic [9:0] raw_word,
   output logic [7:0] data,
   output logic [1:0] ctrl,
   output logic       de,
   output logic       locked,
   output logic [3:0] slip,
   output logic       lock_lost
);
   localparam int RW = $clog2(TOKEN_RUN + 1);
   localparam int WW = $clog2(SEARCH_WINDOW);
   localparam int GW = $clog2(LOSS_TIMEOUT);
   localparam logic [RW-1:0] RUN_LAST = RW'(TOKEN_RUN - 1);
   localparam logic [RW-1:0] RUN_MAX  = RW'(TOKEN_RUN);
   localparam logic [WW-1:0] WIN_LAST = WW'(SEARCH_WINDOW - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(LOSS_TIMEOUT - 1);

   typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [9:0]    prev_q, s1_q;
   logic [19:0]   window;
   logic [9:0]    aligned;
   logic [3:0]    offset_q, offset_d, offset_nxt;
   logic [RW-1:0] run_q, run_d;
   logic [WW-1:0] win_q, win_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          skip_q, skip_d, lost_q, lost_d;
   logic          is_tok;
   logic [1:0]    tok_cd;
   logic [7:0]    qp, dec;
   logic [7:0]    data_q, data_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic          de_q, de_d;

   assign window     = {raw_word, prev_q};
   assign aligned    = 10'(window >> offset_q);
   assign offset_nxt = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

   always_comb begin
      is_tok = 1'b1;
      tok_cd = 2'b00;
      case (s1_q)
         10'h354: tok_cd = 2'b00;
         10'h0AB: tok_cd = 2'b01;
         10'h154: tok_cd = 2'b10;
         10'h2AB: tok_cd = 2'b11;
         default: is_tok = 1'b0;
      endcase
   end

   always_comb begin
      qp     = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
      dec    = '0;
      dec[0] = qp[0];
      for (int i = 1; i < 8; i++)
         dec[i] = s1_q[8] ? (qp[i] ^ qp[i-1]) : ~(qp[i] ^ qp[i-1]);
   end

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      run_d    = run_q;
      win_d    = win_q;
      gap_d    = gap_q;
      skip_d   = 1'b0;
      lost_d   = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            win_d = win_q + 1'b1;
            // skip_q marks the cycle whose stage-1 word still used the old offset
            if (skip_q || !is_tok)  run_d = '0;
            else if (run_q != RUN_MAX) run_d = run_q + 1'b1;
            if (is_tok && !skip_q && run_q >= RUN_LAST) begin
               state_d = ST_LOCKED;
               run_d   = '0;
               win_d   = '0;
               gap_d   = '0;
            end else if (win_q == WIN_LAST) begin
               offset_d = offset_nxt;
               run_d    = '0;
               win_d    = '0;
               skip_d   = 1'b1;
            end
         end
         default: begin
            gap_d = is_tok ? '0 : gap_q + 1'b1;
            if (!is_tok && gap_q == GAP_LAST) begin
               state_d  = ST_SEARCH;
               lost_d   = 1'b1;
               offset_d = offset_nxt;
               run_d    = '0;
               win_d    = '0;
               gap_d    = '0;
               skip_d   = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      data_d = '0;
      ctrl_d = '0;
      de_d   = 1'b0;
      if (state_q == ST_LOCKED) begin
         ctrl_d = is_tok ? tok_cd : ctrl_q;
         if (!is_tok) begin
            de_d   = 1'b1;
            data_d = dec;
         end
      end
   end

   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_SEARCH;
         prev_q   <= '0;
         s1_q     <= '0;
         offset_q <= '0;
         run_q    <= '0;
         win_q    <= '0;
         gap_q    <= '0;
         skip_q   <= 1'b0;
         lost_q   <= 1'b0;
         data_q   <= '0;
         ctrl_q   <= '0;
         de_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= raw_word;
         s1_q     <= aligned;
         offset_q <= offset_d;
         run_q    <= run_d;
         win_q    <= win_d;
         gap_q    <= gap_d;
         skip_q   <= skip_d;
         lost_q   <= lost_d;
         data_q   <= data_d;
         ctrl_q   <= ctrl_d;
         de_q     <= de_d;
      end
   end

   assign data      = data_q;
   assign ctrl      = ctrl_q;
   assign de        = de_q;
   assign locked    = (state_q == ST_LOCKED);
   assign slip      = offset_q;
   assign lock_lost = lost_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: serial-stream token generator plus a
// word-level decode model; one task per scenario.
module tb_tmds_channel_decoder;
   localparam int TR = 8, SW = 2048, LT = 2048;

   logic       pixclk   = 1'b0;
   logic       reset    = 1'b1;
   logic [9:0] raw_word = '0;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic       de, locked, lock_lost;
   logic [3:0] slip;

   int vectors = 0, miscompares = 0;
   logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   tmds_channel_decoder #(.TOKEN_RUN(TR), .SEARCH_WINDOW(SW), .LOSS_TIMEOUT(LT)) dut (
      .pixclk(pixclk), .reset(reset), .raw_word(raw_word), .data(data), .ctrl(ctrl),
      .de(de), .locked(locked), .slip(slip), .lock_lost(lock_lost));

   always #5 pixclk = ~pixclk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step(input logic [9:0] w);
      raw_word = w;
      @(posedge pixclk);
      #1;
   endtask

   task automatic hold_reset();
      reset = 1'b1;
      repeat (3) step(10'($urandom));
      reset = 1'b0;
   endtask

   function automatic int tok_idx(input logic [9:0] w);
      for (int i = 0; i < 4; i++) if (w == TOK[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] ref_data(input logic [9:0] q);
      logic [7:0] p;
      p = q[9] ? ~q[7:0] : q[7:0];
      return (p ^ {p[6:0], 1'b0}) ^ (q[8] ? 8'h00 : 8'hFE);
   endfunction

   // Word k of a serial bit stream: d zero bits, then token t repeated, LSB first.
   function automatic logic [9:0] gen_word(input logic [9:0] t, input int d, input int k);
      logic [9:0] w;
      int n;
      w = '0;
      for (int b = 0; b < 10; b++) begin
         n = 10 * k + b;
         w[b] = (n < d) ? 1'b0 : t[(n - d) % 10];
      end
      return w;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(10'($urandom));
         vectors++;
         if ({data, ctrl, de, locked, slip, lock_lost} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: data=%h ctrl=%b de=%b locked=%b slip=%0d lost=%b, expected all 0",
                     i, data, ctrl, de, locked, slip, lock_lost);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_aligned_lock();
      int lk = -1;
      hold_reset();
      for (int n = 1; n <= TR + 3; n++) begin
         step(10'h354);
         if (locked && lk < 0) lk = n;
      end
      vectors++;
      if (lk < 0) begin
         miscompares++;
         $display("FAIL aligned_lock: locked=%b after %0d cycles, expected 1", locked, TR + 3);
      end
      step(10'h354);
      step(10'h354);
      vectors++;
      if ({locked, slip, ctrl, de} !== {1'b1, 4'd0, 2'b00, 1'b0}) begin
         miscompares++;
         $display("FAIL aligned_state: locked=%b slip=%0d ctrl=%b de=%b, expected 1 0 00 0",
                  locked, slip, ctrl, de);
      end
   endtask

   task automatic test_data_decode();
      logic [9:0] hist [$];
      logic [9:0] w, q;
      logic [1:0] last, e_ctrl;
      logic [7:0] e_data;
      logic       e_de;
      int t;
      hist = {10'h354, 10'h354};
      last = 2'b00;
      for (int n = 0; n < 200; n++) begin
         case (n)
            0:       w = 10'h100;
            1:       w = 10'h200;
            2:       w = 10'h0AB;
            3, 4:    w = 10'h100;
            default: w = ($urandom_range(0, 7) == 0) ? TOK[$urandom_range(0, 3)]
                                                     : 10'($urandom_range(0, 1023));
         endcase
         step(w);
         hist.push_back(w);
         q = hist.pop_front();
         t = tok_idx(q);
         if (t >= 0) begin
            last = 2'(t); e_data = 8'h00; e_ctrl = last; e_de = 1'b0;
         end else begin
            e_data = ref_data(q); e_ctrl = last; e_de = 1'b1;
         end
         vectors++;
         if ({data, ctrl, de} !== {e_data, e_ctrl, e_de}) begin
            miscompares++;
            $display("FAIL decode[%0d] word=%h: data=%h ctrl=%b de=%b, expected data=%h ctrl=%b de=%b",
                     n, q, data, ctrl, de, e_data, e_ctrl, e_de);
         end
      end
   endtask

   task automatic test_loss(input int start, input logic [9:0] fill);
      int pulses = 0, at = -1;
      for (int n = 1; n <= LT + 8; n++) begin
         step(fill);
         if (lock_lost) begin
            pulses++;
            if (at < 0) begin
               at = n;
               vectors++;
               if ({locked, slip} !== {1'b0, 4'((start + 1) % 10)}) begin
                  miscompares++;
                  $display("FAIL loss_state: locked=%b slip=%0d, expected 0 %0d",
                           locked, slip, (start + 1) % 10);
               end
            end
         end
      end
      vectors++;
      if (pulses != 1 || at < LT - 4 || at > LT + 6) begin
         miscompares++;
         $display("FAIL loss_pulse: %0d pulses at cycle %0d, expected 1 near cycle %0d", pulses, at, LT);
      end
      vectors++;
      if ({de, locked} !== 2'b00) begin
         miscompares++;
         $display("FAIL loss_after: de=%b locked=%b, expected 0 0", de, locked);
      end
   endtask

   task automatic test_reset_while_locked();
      hold_reset();
      repeat (TR + 6) step(10'h354);
      vectors++;
      if (locked !== 1'b1) begin
         miscompares++;
         $display("FAIL relock: locked=%b, expected 1", locked);
      end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({data, ctrl, de, locked, slip, lock_lost} !== 17'd0) begin
         miscompares++;
         $display("FAIL async_reset: data=%h ctrl=%b de=%b locked=%b slip=%0d, expected all 0",
                  data, ctrl, de, locked, slip);
      end
      @(posedge pixclk); #1;
      step(10'h354);
      reset = 1'b0;
      step(10'h354);
      vectors++;
      if ({locked, slip} !== 5'd0) begin
         miscompares++;
         $display("FAIL post_reset: locked=%b slip=%0d, expected 0 0", locked, slip);
      end
   endtask

   task automatic test_simultaneous(input int late);
      int first;
      hold_reset();
      first = SW - 9 + late;
      for (int n = 1; n <= SW + 2; n++) begin
         step((n >= first && n <= first + 7) ? 10'h354 : 10'h100);
         if (n == SW - 1) begin
            vectors++;
            if (locked !== 1'b0) begin
               miscompares++;
               $display("FAIL simul_early[%0d]: locked=%b, expected 0", late, locked);
            end
         end
         if (n == SW) begin
            vectors++;
            if ({locked, slip} !== (late != 0 ? {1'b0, 4'd1} : {1'b1, 4'd0})) begin
               miscompares++;
               $display("FAIL simul_edge[%0d]: locked=%b slip=%0d, expected %0d %0d",
                        late, locked, slip, late == 0, late);
            end
         end
      end
   endtask

   task automatic test_slip_search(input logic [9:0] t, input int d, input logic [1:0] cd);
      int k = 0;
      hold_reset();
      for (int o = 0; o <= d; o++) begin
         for (int i = 0; i < SW; i++) begin
            step(gen_word(t, d, k));
            k++;
            if (i == SW / 2 && (o == d || o < 4)) begin
               vectors++;
               if (o < d && {slip, locked} !== {4'(o), 1'b0}) begin
                  miscompares++;
                  $display("FAIL slip_step[%0d]: slip=%0d locked=%b, expected %0d 0", o, slip, locked, o);
               end else if (o == d && {slip, locked, ctrl, de} !== {4'(d), 1'b1, cd, 1'b0}) begin
                  miscompares++;
                  $display("FAIL slip_lock: slip=%0d locked=%b ctrl=%b de=%b, expected %0d 1 %b 0",
                           slip, locked, ctrl, de, d, cd);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_aligned_lock();
      test_data_decode();
      test_loss(0, 10'h100);
      test_reset_while_locked();
      test_simultaneous(0);
      test_simultaneous(1);
      test_slip_search(10'h2AB, 3, 2'b11);
      test_loss(3, 10'h100);
      test_slip_search(10'h154, 9, 2'b10);
      test_loss(9, 10'h100);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
